// File: rtl/seq_alu.sv
// seq_alu: multi-cycle execute-stage ALU that uses the processor's 8-bit
// opcode encoding.
//   clk     rising-edge clock
//   rst_n   synchronous active-low reset
//   start   operation request, accepted only while busy = 0
//   opcode  operation code (Inst[31:24] encoding)
//   op_a    operand 1
//   op_b    operand 2 / shift amount in op_b[SHW-1:0]
//   busy    iterative MUL/DIV in progress
//   done    one-cycle pulse, result/ext/cb valid
//   result  low result / quotient
//   ext     MUL high half / DIV remainder, 0 otherwise
//   cb      carry/borrow, or divide-by-zero flag
// Single-cycle ops complete on the accept edge. MUL (shift-add) and DIV
// (restoring) run one bit per cycle through IDLE -> ITER -> FIN.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       opcode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] ext,
  output logic             cb
);

  localparam logic [7:0] OP_ADD  = 8'h07;
  localparam logic [7:0] OP_SUB  = 8'h08;
  localparam logic [7:0] OP_MUL  = 8'h09;
  localparam logic [7:0] OP_DIV  = 8'h0A;
  localparam logic [7:0] OP_AND  = 8'h0B;
  localparam logic [7:0] OP_OR   = 8'h0C;
  localparam logic [7:0] OP_XOR  = 8'h0D;
  localparam logic [7:0] OP_NOR  = 8'h0E;
  localparam logic [7:0] OP_NAND = 8'h0F;
  localparam logic [7:0] OP_NOT  = 8'h16;
  localparam logic [7:0] OP_INC  = 8'h17;
  localparam logic [7:0] OP_DEC  = 8'h18;
  localparam logic [7:0] OP_SR   = 8'h19;
  localparam logic [7:0] OP_SL   = 8'h20;
  localparam logic [7:0] OP_AR   = 8'h21;
  localparam logic [7:0] OP_CIR  = 8'h22;
  localparam logic [7:0] OP_CIL  = 8'h23;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state_r, state_nx_s;
  logic [SHW-1:0]     cnt_r;
  logic               is_div_r;
  logic [WIDTH-1:0]   d_r;       // multiplicand or divisor
  logic [WIDTH-1:0]   hi_r;      // product high half / partial remainder
  logic [WIDTH-1:0]   lo_r;      // multiplier, then product low / quotient
  logic [WIDTH-1:0]   hi_nx_s, lo_nx_s;
  logic [WIDTH:0]     step_s;
  logic               busy_r, done_r, cb_r;
  logic [WIDTH-1:0]   result_r, ext_r;
  logic               iter_go_s;
  logic [WIDTH-1:0]   sc_res_s;
  logic               sc_cb_s;
  logic [2*WIDTH-1:0] rot_s;
  logic [SHW-1:0]     shamt_s;

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign ext    = ext_r;
  assign cb     = cb_r;

  assign shamt_s = op_b[SHW-1:0];

  // Decide whether an accepted start needs the iterative path.
  always_comb begin
    iter_go_s = 1'b0;
    if (opcode == OP_MUL) begin
      iter_go_s = 1'b1;
    end else if ((opcode == OP_DIV) && (op_b != {WIDTH{1'b0}})) begin
      iter_go_s = 1'b1;
    end else begin
      iter_go_s = 1'b0;
    end
  end

  // Single-cycle operation results, computed from the live inputs at accept.
  always_comb begin
    sc_res_s = op_a;
    sc_cb_s  = 1'b0;
    rot_s    = {op_a, op_a};
    case (opcode)
      OP_ADD:  {sc_cb_s, sc_res_s} = {1'b0, op_a} + {1'b0, op_b};
      OP_SUB:  {sc_cb_s, sc_res_s} = {1'b0, op_a} - {1'b0, op_b};
      OP_INC:  {sc_cb_s, sc_res_s} = {1'b0, op_a} + {{WIDTH{1'b0}}, 1'b1};
      OP_DEC:  {sc_cb_s, sc_res_s} = {1'b0, op_a} - {{WIDTH{1'b0}}, 1'b1};
      OP_AND:  sc_res_s = op_a & op_b;
      OP_OR:   sc_res_s = op_a | op_b;
      OP_XOR:  sc_res_s = op_a ^ op_b;
      OP_NOR:  sc_res_s = ~(op_a | op_b);
      OP_NAND: sc_res_s = ~(op_a & op_b);
      OP_NOT:  sc_res_s = ~op_a;
      OP_SR:   sc_res_s = op_a >> shamt_s;
      OP_SL:   sc_res_s = op_a << shamt_s;
      OP_AR:   sc_res_s = WIDTH'($signed(op_a) >>> shamt_s);
      // Rotates shift the doubled word so bits wrap in from the other copy.
      OP_CIR: begin
        rot_s    = {op_a, op_a} >> shamt_s;
        sc_res_s = rot_s[WIDTH-1:0];
      end
      OP_CIL: begin
        rot_s    = {op_a, op_a} << shamt_s;
        sc_res_s = rot_s[2*WIDTH-1:WIDTH];
      end
      // Only reached on this path with a zero divisor.
      OP_DIV: begin
        sc_res_s = {WIDTH{1'b0}};
        sc_cb_s  = 1'b1;
      end
      default: begin
        sc_res_s = op_a;
        sc_cb_s  = 1'b0;
      end
    endcase
  end

  // One shift-add or restoring-divide iteration on the hi/lo pair.
  always_comb begin
    step_s  = {(WIDTH+1){1'b0}};
    hi_nx_s = hi_r;
    lo_nx_s = lo_r;
    if (is_div_r) begin
      step_s = {hi_r, lo_r[WIDTH-1]};
      if (step_s >= {1'b0, d_r}) begin
        step_s  = step_s - {1'b0, d_r};
        lo_nx_s = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        lo_nx_s = {lo_r[WIDTH-2:0], 1'b0};
      end
      hi_nx_s = step_s[WIDTH-1:0];
    end else begin
      if (lo_r[0]) begin
        step_s = {1'b0, hi_r} + {1'b0, d_r};
      end else begin
        step_s = {1'b0, hi_r};
      end
      hi_nx_s = step_s[WIDTH:1];
      lo_nx_s = {step_s[0], lo_r[WIDTH-1:1]};
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start && iter_go_s) begin
          state_nx_s = ITER;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ITER: begin
        if (cnt_r == CNT_LAST) begin
          state_nx_s = FIN;
        end else begin
          state_nx_s = ITER;
        end
      end
      FIN:     state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= {SHW{1'b0}};
      is_div_r <= 1'b0;
      d_r      <= {WIDTH{1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {WIDTH{1'b0}};
      ext_r    <= {WIDTH{1'b0}};
      cb_r     <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s != IDLE);
      done_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (iter_go_s) begin
              is_div_r <= (opcode == OP_DIV);
              cnt_r    <= {SHW{1'b0}};
              hi_r     <= {WIDTH{1'b0}};
              // DIV shifts the dividend out of lo; MUL consumes the multiplier.
              d_r      <= (opcode == OP_DIV) ? op_b : op_a;
              lo_r     <= (opcode == OP_DIV) ? op_a : op_b;
            end else begin
              result_r <= sc_res_s;
              ext_r    <= {WIDTH{1'b0}};
              cb_r     <= sc_cb_s;
              done_r   <= 1'b1;
            end
          end
        end
        ITER: begin
          hi_r  <= hi_nx_s;
          lo_r  <= lo_nx_s;
          cnt_r <= cnt_r + {{(SHW-1){1'b0}}, 1'b1};
        end
        FIN: begin
          result_r <= lo_r;
          ext_r    <= hi_r;
          cb_r     <= 1'b0;
          done_r   <= 1'b1;
        end
        default: begin
          cnt_r <= {SHW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu (WIDTH = 32) with hand-computed expectations.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  opcode = 8'h00;
  logic [31:0] op_a = 32'h0;
  logic [31:0] op_b = 32'h0;
  logic        busy, done, cb;
  logic [31:0] result, ext;

  int errors = 0;
  int checks = 0;
  int n;
  int busy_cnt;
  int done_cnt;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .result(result), .ext(ext), .cb(cb)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one start for a single edge; returns just after the accept edge.
  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    opcode = op; op_a = a; op_b = b; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Advance until done (bounded); n = edges after the accept edge.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  // Single-cycle op: done right after accept, with the given outputs.
  task automatic single(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ec);
    issue(op, a, b);
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_res"}, {32'd0, result}, {32'd0, er});
    chk({tag, "_ext"}, {32'd0, ext}, 64'd0);
    chk({tag, "_cb"}, {63'd0, cb}, {63'd0, ec});
  endtask

  initial begin
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_res", {32'd0, result}, 64'd0);

    // Carry out and borrow.
    single("add_carry", 8'h07, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1);
    step();
    chk("add_done_drop", {63'd0, done}, 64'd0);
    single("sub_borrow", 8'h08, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b1);
    single("xor", 8'h0D, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 1'b0);
    single("nand", 8'h0F, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 1'b0);
    single("not", 8'h16, 32'h0000FFFF, 32'h0, 32'hFFFF0000, 1'b0);
    single("dec_zero", 8'h18, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b1);
    single("inc", 8'h17, 32'h7FFFFFFF, 32'h0, 32'h80000000, 1'b0);

    // Shifts and rotates.
    single("ar4", 8'h21, 32'h80000000, 32'd4, 32'hF8000000, 1'b0);
    single("cil1", 8'h23, 32'h80000001, 32'd1, 32'h00000003, 1'b0);
    single("cir1", 8'h22, 32'h00000003, 32'd1, 32'h80000001, 1'b0);
    single("sl_21h", 8'h20, 32'h12345678, 32'h00000021, 32'h2468ACF0, 1'b0);
    single("sr0", 8'h19, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0);
    step();

    // MUL with an ignored start and operand changes while busy.
    issue(8'h09, 32'hFFFFFFFF, 32'hFFFFFFFF);
    n = 0; busy_cnt = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy === 1'b1) busy_cnt++;
      if (n == 5) begin
        opcode = 8'h07; op_a = 32'd1; op_b = 32'd1; start = 1'b1;
      end else begin
        start = 1'b0; op_a = 32'h0; op_b = 32'h0;
      end
      step();
      n++;
    end
    chk("mul_lat", n, 64'd33);
    chk("mul_busy_cycles", busy_cnt, 64'd33);
    chk("mul_busy_at_done", {63'd0, busy}, 64'd0);
    chk("mul_lo", {32'd0, result}, 64'h00000001);
    chk("mul_hi", {32'd0, ext}, 64'hFFFFFFFE);
    chk("mul_cb", {63'd0, cb}, 64'd0);
    step();
    chk("mul_no_extra_done", {63'd0, done}, 64'd0);

    // Restoring divide, then divide by zero.
    issue(8'h0A, 32'd100, 32'd7);
    wait_done(n);
    chk("div_lat", n, 64'd33);
    chk("div_q", {32'd0, result}, 64'd14);
    chk("div_r", {32'd0, ext}, 64'd2);
    chk("div_cb", {63'd0, cb}, 64'd0);
    step();
    single("div_zero", 8'h0A, 32'd1234, 32'd0, 32'd0, 1'b1);
    step();
    chk("div_zero_busy_after", {63'd0, busy}, 64'd0);

    // Back-to-back: ADD issued in the DIV done cycle, then a passthrough op.
    issue(8'h0A, 32'd1000, 32'd7);
    wait_done(n);
    chk("b2b_div_lat", n, 64'd33);
    chk("b2b_div_q", {32'd0, result}, 64'd142);
    chk("b2b_div_r", {32'd0, ext}, 64'd6);
    single("b2b_add", 8'h07, 32'd2, 32'd3, 32'd5, 1'b0);
    single("b2b_hlt", 8'hFF, 32'hCAFEF00D, 32'd123, 32'hCAFEF00D, 1'b0);
    step();
    chk("b2b_done_drop", {63'd0, done}, 64'd0);

    // Reset in the middle of a MUL aborts it without a done pulse.
    issue(8'h09, 32'd3, 32'd5);
    step(); step(); step();
    chk("rst_mid_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    chk("rst_mid_busy0", {63'd0, busy}, 64'd0);
    chk("rst_mid_done0", {63'd0, done}, 64'd0);
    chk("rst_mid_res0", {32'd0, result}, 64'd0);
    chk("rst_mid_ext0", {32'd0, ext}, 64'd0);
    chk("rst_mid_cb0", {63'd0, cb}, 64'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done === 1'b1) done_cnt++;
    end
    chk("rst_mid_no_done", done_cnt, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
